// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words, compares them
// against build-time constants and reports the result on status flags and a board LED.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd12345678,
  parameter logic [31:0] EXPECTED_TS  = 32'd1431967266,
  parameter int          READ_LATENCY = 1,
  parameter bit          AUTO_START   = 1'b1,
  parameter int          BLINK_DIV    = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        led
);

  localparam int             CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]  BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [1:0]     LAT_LAST   = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    CMP   = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [1:0]     lat_cnt_r, lat_cnt_s;
  logic           cap_id_s, cap_ts_s;
  logic           auto_r;
  logic           busy_r, done_r, read_r, addr_r;
  logic [31:0]    read_id_r, read_ts_r;
  logic           id_ok_r, ts_ok_r, pass_r;
  logic           id_ok_s, ts_ok_s;
  logic           led_r, fail_r;
  logic [CW-1:0]  blink_cnt_r;

  // Next-state, latency counting and capture strobes.
  always_comb begin
    state_s   = state_r;
    lat_cnt_s = lat_cnt_r;
    cap_id_s  = 1'b0;
    cap_ts_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start || auto_r) begin
          state_s = RD_ID;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ID: begin
        lat_cnt_s = 2'd0;
        if (READ_LATENCY == 0) begin
          cap_id_s = 1'b1;
          state_s  = RD_TS;
        end else begin
          state_s  = WT_ID;
        end
      end
      WT_ID: begin
        if (lat_cnt_r == LAT_LAST) begin
          cap_id_s  = 1'b1;
          lat_cnt_s = 2'd0;
          state_s   = RD_TS;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      RD_TS: begin
        lat_cnt_s = 2'd0;
        if (READ_LATENCY == 0) begin
          cap_ts_s = 1'b1;
          state_s  = CMP;
        end else begin
          state_s  = WT_TS;
        end
      end
      WT_TS: begin
        if (lat_cnt_r == LAT_LAST) begin
          cap_ts_s  = 1'b1;
          lat_cnt_s = 2'd0;
          state_s   = CMP;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      CMP:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // The ID word is already held when the timestamp arrives, so both verdicts form together.
  assign id_ok_s = (read_id_r == EXPECTED_ID);
  assign ts_ok_s = (sysid_readdata == EXPECTED_TS);

  // State register, bus strobes, captured words and verdict flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      lat_cnt_r <= 2'd0;
      auto_r    <= AUTO_START;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      read_r    <= 1'b0;
      addr_r    <= 1'b0;
      read_id_r <= 32'd0;
      read_ts_r <= 32'd0;
      id_ok_r   <= 1'b0;
      ts_ok_r   <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      lat_cnt_r <= lat_cnt_s;
      auto_r    <= 1'b0;
      busy_r    <= (state_s == RD_ID) || (state_s == WT_ID) ||
                   (state_s == RD_TS) || (state_s == WT_TS);
      done_r    <= (state_s == CMP);
      read_r    <= (state_s == RD_ID) || (state_s == RD_TS);
      addr_r    <= (state_s == RD_TS) || (state_s == WT_TS);
      if (cap_id_s) begin
        read_id_r <= sysid_readdata;
      end
      if (cap_ts_s) begin
        read_ts_r <= sysid_readdata;
        id_ok_r   <= id_ok_s;
        ts_ok_r   <= ts_ok_s;
        pass_r    <= id_ok_s & ts_ok_s;
      end
    end
  end

  // LED: solid on pass, blinking from 1 on fail, restarting with every new verdict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_r       <= 1'b0;
      fail_r      <= 1'b0;
      blink_cnt_r <= '0;
    end else if (cap_ts_s) begin
      led_r       <= 1'b1;
      fail_r      <= ~(id_ok_s & ts_ok_s);
      blink_cnt_r <= '0;
    end else if (fail_r) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        led_r       <= ~led_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + CNT_ONE;
      end
    end
  end

  assign sysid_address = addr_r;
  assign sysid_read    = read_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign read_id       = read_id_r;
  assign read_ts       = read_ts_r;
  assign id_ok         = id_ok_r;
  assign ts_ok         = ts_ok_r;
  assign pass          = pass_r;
  assign led           = led_r;

endmodule
